// File: rtl/rv32_imm_gen_pipe.sv
// rv32_imm_gen_pipe: pipelined RISC-V immediate generator for the decode stage.
// Decodes the immediate of each accepted instruction (type from imm_type_in, or
// from the opcode when AUTO_TYPE=1) and buffers results in a 2-entry FIFO.
// Ports:
//   clk_in, rst_n_in            clock, synchronous active-low reset
//   in_valid_in / in_ready_out  input handshake (ready is registered)
//   instr_in, imm_type_in       instruction word, external type code
//   tag_in / tag_out            sideband tag, returned unchanged
//   out_valid_out / out_ready_in output handshake for the queue head
//   imm_out, imm_type_out       immediate (XLEN wide) and type used
//   err_out                     auto mode: unrecognised opcode (imm forced to 0)
module rv32_imm_gen_pipe #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned AUTO_TYPE = 0,
    parameter int unsigned TAG_W     = 4
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             in_valid_in,
    output logic             in_ready_out,
    input  logic [31:0]      instr_in,
    input  logic [2:0]       imm_type_in,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid_out,
    input  logic             out_ready_in,
    output logic [XLEN-1:0]  imm_out,
    output logic [2:0]       imm_type_out,
    output logic [TAG_W-1:0] tag_out,
    output logic             err_out
);

    localparam int unsigned CNT_W   = 2;
    localparam bit          IS_RV64 = (XLEN == 64);
    localparam bit          AUTO_EN = (AUTO_TYPE != 0);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       typ;
        logic [TAG_W-1:0] tag;
        logic             err;
    } entry_t;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_nxt;
    logic             ready_q;
    logic             valid_q;
    entry_t           head_q;
    entry_t           tail_q;
    entry_t           new_entry;

    logic [2:0]  auto_type;
    logic        auto_err;
    logic [2:0]  sel_type;
    logic        sel_err;
    logic [31:0] imm32;
    logic        push;
    logic        pop;

    assign push = in_valid_in && ready_q;
    assign pop  = valid_q && out_ready_in;

    // Opcode decode for auto mode; every legal opcode ends in 2'b11, so
    // compressed/illegal encodings fall into the default error case.
    always_comb begin
        auto_type = 3'b000;
        auto_err  = 1'b0;
        case (instr_in[6:0])
            7'b0010011: auto_type = 3'b000;
            7'b0011011: auto_err  = !IS_RV64;
            7'b0000011: auto_type = 3'b001;
            7'b0100011: auto_type = 3'b010;
            7'b1100011: auto_type = 3'b011;
            7'b0110111,
            7'b0010111: auto_type = 3'b100;
            7'b1101111: auto_type = 3'b101;
            7'b1100111: auto_type = 3'b111;
            7'b1110011: auto_type = instr_in[14] ? 3'b110 : 3'b000;
            default:    auto_err  = 1'b1;
        endcase
    end

    // Immediate formation at 32 bits; every form is sign-extended from bit 31
    // to XLEN (the CSR zimm form has bit 31 clear, so it stays zero-extended).
    always_comb begin
        sel_type = imm_type_in;
        sel_err  = 1'b0;
        if (AUTO_EN) begin
            sel_type = auto_err ? 3'b000 : auto_type;
            sel_err  = auto_err;
        end
        case (sel_type)
            3'b010:  imm32 = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
            3'b011:  imm32 = {{19{instr_in[31]}}, instr_in[31], instr_in[7],
                              instr_in[30:25], instr_in[11:8], 1'b0};
            3'b100:  imm32 = {instr_in[31:12], 12'h000};
            3'b101:  imm32 = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12],
                              instr_in[20], instr_in[30:21], 1'b0};
            3'b110:  imm32 = {27'd0, instr_in[19:15]};
            default: imm32 = {{20{instr_in[31]}}, instr_in[31:20]};
        endcase
        new_entry.imm = sel_err ? '0 : XLEN'($signed(imm32));
        new_entry.typ = sel_type;
        new_entry.tag = tag_in;
        new_entry.err = sel_err;
    end

    // Occupancy next-state; push is never true at count 2 since ready_q tracks count.
    always_comb begin
        count_nxt = count_q;
        case ({push, pop})
            2'b10:   count_nxt = count_q + CNT_W'(1);
            2'b01:   count_nxt = count_q - CNT_W'(1);
            default: count_nxt = count_q;
        endcase
    end

    // Queue storage: head_q drives the outputs directly, tail_q is the second slot.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            count_q <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q <= count_nxt;
            ready_q <= (count_nxt != CNT_W'(2));
            valid_q <= (count_nxt != CNT_W'(0));
            if (pop) begin
                if (count_q == CNT_W'(2)) begin
                    head_q <= tail_q;
                end else if (push) begin
                    head_q <= new_entry;
                end
            end else if (push) begin
                if (count_q == CNT_W'(0)) begin
                    head_q <= new_entry;
                end else begin
                    tail_q <= new_entry;
                end
            end
        end
    end

    assign in_ready_out  = ready_q;
    assign out_valid_out = valid_q;
    assign imm_out       = head_q.imm;
    assign imm_type_out  = head_q.typ;
    assign tag_out       = head_q.tag;
    assign err_out       = head_q.err;

endmodule

// File: tb/tb_rv32_imm_gen_pipe.sv
// Bench for rv32_imm_gen_pipe: instance A (XLEN=32, external type) and
// instance B (XLEN=64, auto type), scoreboard queues per instance.
module tb_rv32_imm_gen_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance A
    logic        a_iv, a_ir, a_ov, a_or, a_err;
    logic [31:0] a_instr, a_imm;
    logic [2:0]  a_type, a_ot;
    logic [3:0]  a_tag, a_otag;
    // Instance B
    logic        b_iv, b_ir, b_ov, b_or, b_err;
    logic [31:0] b_instr;
    logic [63:0] b_imm;
    logic [2:0]  b_type, b_ot;
    logic [3:0]  b_tag, b_otag;

    rv32_imm_gen_pipe #(.XLEN(32), .AUTO_TYPE(0), .TAG_W(4)) dut_a (
        .clk_in(clk), .rst_n_in(rst_n),
        .in_valid_in(a_iv), .in_ready_out(a_ir),
        .instr_in(a_instr), .imm_type_in(a_type), .tag_in(a_tag),
        .out_valid_out(a_ov), .out_ready_in(a_or),
        .imm_out(a_imm), .imm_type_out(a_ot), .tag_out(a_otag), .err_out(a_err)
    );

    rv32_imm_gen_pipe #(.XLEN(64), .AUTO_TYPE(1), .TAG_W(4)) dut_b (
        .clk_in(clk), .rst_n_in(rst_n),
        .in_valid_in(b_iv), .in_ready_out(b_ir),
        .instr_in(b_instr), .imm_type_in(b_type), .tag_in(b_tag),
        .out_valid_out(b_ov), .out_ready_in(b_or),
        .imm_out(b_imm), .imm_type_out(b_ot), .tag_out(b_otag), .err_out(b_err)
    );

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  t;
        logic [3:0]  tag;
        logic        err;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference immediate at 64 bits, straight from the type table.
    function automatic logic [63:0] f_imm(input logic [31:0] i, input logic [2:0] t);
        case (t)
            3'd2:    return {{52{i[31]}}, i[31:25], i[11:7]};
            3'd3:    return {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd4:    return {{32{i[31]}}, i[31:12], 12'h000};
            3'd5:    return {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            3'd6:    return {59'd0, i[19:15]};
            default: return {{52{i[31]}}, i[31:20]};
        endcase
    endfunction

    // Reference opcode decode for a 64-bit auto instance: returns {err, type}.
    function automatic logic [3:0] f_auto(input logic [31:0] i);
        case (i[6:0])
            7'h13, 7'h1B: return 4'b0000;
            7'h03:        return 4'b0001;
            7'h23:        return 4'b0010;
            7'h63:        return 4'b0011;
            7'h37, 7'h17: return 4'b0100;
            7'h6F:        return 4'b0101;
            7'h67:        return 4'b0111;
            7'h73:        return i[14] ? 4'b0110 : 4'b0000;
            default:      return 4'b1000;
        endcase
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        a_iv = 0; a_or = 0; a_instr = '0; a_type = '0; a_tag = '0;
        b_iv = 0; b_or = 0; b_instr = '0; b_type = '0; b_tag = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({a_ov, a_ir, a_imm, a_ot, a_otag, a_err} !== {1'b0, 1'b1, 32'd0, 3'd0, 4'd0, 1'b0})
            $display("FAIL reset_a: got ov=%b ir=%b imm=%h t=%h tag=%h err=%b, want ov=0 ir=1 rest 0",
                     a_ov, a_ir, a_imm, a_ot, a_otag, a_err);
        else n_pass++;
        n_checks++;
        if ({b_ov, b_ir, b_imm, b_ot, b_otag, b_err} !== {1'b0, 1'b1, 64'd0, 3'd0, 4'd0, 1'b0})
            $display("FAIL reset_b: got ov=%b ir=%b imm=%h t=%h tag=%h err=%b, want ov=0 ir=1 rest 0",
                     b_ov, b_ir, b_imm, b_ot, b_otag, b_err);
        else n_pass++;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_latency();
        a_iv = 1; a_instr = 32'hFFF00093; a_type = 3'd0; a_tag = 4'd5; a_or = 0;
        @(posedge clk); #1;
        a_iv = 0;
        n_checks++;
        if ({a_ov, a_imm, a_ot, a_otag, a_err} !== {1'b1, 32'hFFFFFFFF, 3'd0, 4'd5, 1'b0})
            $display("FAIL latency_addi: got ov=%b imm=%h t=%h tag=%h err=%b, want ov=1 imm=ffffffff t=0 tag=5 err=0",
                     a_ov, a_imm, a_ot, a_otag, a_err);
        else n_pass++;
        a_or = 1;
        @(posedge clk); #1;
        a_or = 0;
        n_checks++;
        if ({a_ov, a_ir} !== 2'b01)
            $display("FAIL latency_drain: got ov=%b ir=%b, want ov=0 ir=1", a_ov, a_ir);
        else n_pass++;
    endtask

    task automatic test_type_forms();
        logic [31:0] vi[$];
        logic [2:0]  vt[$];
        logic [63:0] ve[$];
        int idx = 0;
        int cyc = 0;
        exp_t e;
        vi.push_back(32'hFFF00093); vt.push_back(3'd0); ve.push_back(64'hFFFFFFFFFFFFFFFF);
        vi.push_back(32'hFE000EE3); vt.push_back(3'd3); ve.push_back(64'hFFFFFFFFFFFFFFFC);
        vi.push_back(32'h0000006F); vt.push_back(3'd5); ve.push_back(64'd0);
        for (int k = 0; k < 16; k++) begin
            logic [31:0] r;
            logic [2:0]  t;
            r = $urandom();
            t = 3'(k % 8);
            vi.push_back(r); vt.push_back(t); ve.push_back(f_imm(r, t));
        end
        while ((idx < vi.size() || qa.size() != 0) && cyc < 500) begin
            a_iv = (idx < vi.size());
            if (a_iv) begin
                a_instr = vi[idx]; a_type = vt[idx]; a_tag = 4'(idx);
            end
            a_or = ($urandom_range(0, 3) != 0);
            if (a_ov && a_or) begin
                n_checks++;
                if (qa.size() == 0) begin
                    $display("FAIL forms_spurious: got unexpected output imm=%h, want none", a_imm);
                end else begin
                    e = qa.pop_front();
                    if ({a_imm, a_ot, a_otag, a_err} !== {e.imm[31:0], e.t, e.tag, e.err})
                        $display("FAIL forms_out: got imm=%h t=%h tag=%h err=%b, want imm=%h t=%h tag=%h err=%b",
                                 a_imm, a_ot, a_otag, a_err, e.imm[31:0], e.t, e.tag, e.err);
                    else n_pass++;
                end
            end
            if (a_iv && a_ir) begin
                qa.push_back('{imm: ve[idx], t: vt[idx], tag: 4'(idx), err: 1'b0});
                idx++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        a_iv = 0; a_or = 0;
        n_checks++;
        if (idx != vi.size() || qa.size() != 0)
            $display("FAIL forms_timeout: got sent=%0d pending=%0d, want sent=%0d pending=0",
                     idx, qa.size(), vi.size());
        else n_pass++;
    endtask

    task automatic test_auto_back_to_back();
        logic [6:0]  ops[10] = '{7'h13, 7'h1B, 7'h03, 7'h23, 7'h63,
                                 7'h37, 7'h17, 7'h6F, 7'h67, 7'h73};
        logic [31:0] vi[$];
        int idx = 0;
        int cyc = 0;
        exp_t e;
        vi.push_back(32'h800000B7);
        vi.push_back(32'h3400D073);
        vi.push_back(32'h0000007F);
        vi.push_back(32'hFFFFF010);
        for (int k = 0; k < 20; k++) begin
            logic [31:0] r;
            r = $urandom();
            vi.push_back({r[31:7], ops[k % 10]});
        end
        b_or = 1;
        while ((idx < vi.size() || qb.size() != 0) && cyc < 500) begin
            b_iv = (idx < vi.size());
            b_type = 3'($urandom_range(0, 7));
            if (b_iv) begin
                b_instr = vi[idx]; b_tag = 4'(idx);
            end
            if (b_ov && b_or) begin
                n_checks++;
                if (qb.size() == 0) begin
                    $display("FAIL auto_spurious: got unexpected output imm=%h, want none", b_imm);
                end else begin
                    e = qb.pop_front();
                    if ({b_imm, b_ot, b_otag, b_err} !== {e.imm, e.t, e.tag, e.err})
                        $display("FAIL auto_out: got imm=%h t=%h tag=%h err=%b, want imm=%h t=%h tag=%h err=%b",
                                 b_imm, b_ot, b_otag, b_err, e.imm, e.t, e.tag, e.err);
                    else n_pass++;
                end
            end
            if (b_iv && b_ir) begin
                logic [3:0] d;
                case (idx)
                    0: e = '{imm: 64'hFFFFFFFF80000000, t: 3'd4, tag: 4'(idx), err: 1'b0};
                    1: e = '{imm: 64'd1, t: 3'd6, tag: 4'(idx), err: 1'b0};
                    2, 3: e = '{imm: 64'd0, t: 3'd0, tag: 4'(idx), err: 1'b1};
                    default: begin
                        d = f_auto(vi[idx]);
                        e = '{imm: d[3] ? 64'd0 : f_imm(vi[idx], d[2:0]),
                              t: d[3] ? 3'd0 : d[2:0], tag: 4'(idx), err: d[3]};
                    end
                endcase
                qb.push_back(e);
                idx++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        b_iv = 0; b_or = 0;
        n_checks++;
        if (idx != vi.size() || qb.size() != 0 || cyc != vi.size() + 1)
            $display("FAIL auto_throughput: got sent=%0d pending=%0d cycles=%0d, want sent=%0d pending=0 cycles=%0d",
                     idx, qb.size(), cyc, vi.size(), vi.size() + 1);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [31:0] vi[5];
        logic [2:0]  vt[5];
        int idx = 0;
        int cyc = 0;
        exp_t e;
        for (int k = 0; k < 5; k++) begin
            vi[k] = $urandom();
            vt[k] = 3'($urandom_range(0, 7));
        end
        a_or = 0;
        for (int c = 0; c < 8; c++) begin
            a_iv = (idx < 5);
            if (a_iv) begin
                a_instr = vi[idx]; a_type = vt[idx]; a_tag = 4'(idx + 8);
            end
            if (a_iv && a_ir) begin
                qa.push_back('{imm: f_imm(vi[idx], vt[idx]), t: vt[idx], tag: 4'(idx + 8), err: 1'b0});
                idx++;
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (idx != 2 || a_ir !== 1'b0 || a_ov !== 1'b1)
            $display("FAIL bp_full: got accepted=%0d ir=%b ov=%b, want accepted=2 ir=0 ov=1", idx, a_ir, a_ov);
        else n_pass++;
        n_checks++;
        if (qa.size() == 0 || a_imm !== qa[0].imm[31:0] || a_otag !== qa[0].tag)
            $display("FAIL bp_head_hold: got imm=%h tag=%h, want first accepted entry", a_imm, a_otag);
        else n_pass++;
        a_or = 1;
        while ((idx < 5 || qa.size() != 0) && cyc < 100) begin
            a_iv = (idx < 5);
            if (a_iv) begin
                a_instr = vi[idx]; a_type = vt[idx]; a_tag = 4'(idx + 8);
            end
            if (a_ov && a_or) begin
                n_checks++;
                if (qa.size() == 0) begin
                    $display("FAIL bp_spurious: got unexpected output imm=%h, want none", a_imm);
                end else begin
                    e = qa.pop_front();
                    if ({a_imm, a_ot, a_otag, a_err} !== {e.imm[31:0], e.t, e.tag, e.err})
                        $display("FAIL bp_out: got imm=%h t=%h tag=%h err=%b, want imm=%h t=%h tag=%h err=%b",
                                 a_imm, a_ot, a_otag, a_err, e.imm[31:0], e.t, e.tag, e.err);
                    else n_pass++;
                end
            end
            if (a_iv && a_ir) begin
                qa.push_back('{imm: f_imm(vi[idx], vt[idx]), t: vt[idx], tag: 4'(idx + 8), err: 1'b0});
                idx++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        a_iv = 0; a_or = 0;
        n_checks++;
        if (idx != 5 || qa.size() != 0 || cyc != 5)
            $display("FAIL bp_release: got sent=%0d pending=%0d cycles=%0d, want sent=5 pending=0 cycles=5",
                     idx, qa.size(), cyc);
        else n_pass++;
    endtask

    task automatic test_reset_midop();
        a_or = 0;
        a_iv = 1; a_instr = 32'hFFF00093; a_type = 3'd0; a_tag = 4'd3;
        @(posedge clk); #1;
        a_instr = 32'hFE000EE3; a_type = 3'd3; a_tag = 4'd4;
        @(posedge clk); #1;
        a_iv = 0;
        n_checks++;
        if ({a_ov, a_ir} !== 2'b10)
            $display("FAIL midop_full: got ov=%b ir=%b, want ov=1 ir=0", a_ov, a_ir);
        else n_pass++;
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        n_checks++;
        if ({a_ov, a_ir, a_imm, a_ot, a_otag, a_err} !== {1'b0, 1'b1, 32'd0, 3'd0, 4'd0, 1'b0})
            $display("FAIL midop_reset: got ov=%b ir=%b imm=%h t=%h tag=%h err=%b, want ov=0 ir=1 rest 0",
                     a_ov, a_ir, a_imm, a_ot, a_otag, a_err);
        else n_pass++;
        a_or = 1;
        @(posedge clk); #1;
        a_or = 0;
        n_checks++;
        if ({a_ov, a_ir} !== 2'b01)
            $display("FAIL midop_lost: got ov=%b ir=%b, want ov=0 ir=1", a_ov, a_ir);
        else n_pass++;
        qa.delete();
        qb.delete();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_type_forms();
        test_auto_back_to_back();
        test_backpressure();
        test_reset_midop();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rv32_imm_gen_pipe.md
# rv32_imm_gen_pipe

- Pipelined, parametrised immediate generator for the decode stage.
- Accepts 32-bit instruction words under a valid/ready handshake and forms the sign- or zero-extended immediate at XLEN width.
- Immediate type comes either from the external type code or from the opcode (auto mode).
- Results are buffered in a 2-entry output queue, so the block sustains one instruction per cycle and absorbs downstream stalls without a combinational ready path.

## Interface
Parameters:
- XLEN, 32, immediate/output width; legal values 32 or 64.
- AUTO_TYPE, 0, 1 = derive type from opcode and ignore imm_type_in; 0 = use imm_type_in.
- TAG_W, 4, width of the sideband tag carried with each instruction.

Ports:
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_n_in  input  1  reset, synchronous, active-low.
- in_valid_in  input  1  instruction offered.
- in_ready_out  output  1  block can accept; registered.
- instr_in  input  32  instruction word.
- imm_type_in  input  3  type code, used when AUTO_TYPE=0.
- tag_in  input  TAG_W  sideband, returned unchanged.
- out_valid_out  output  1  result at queue head valid.
- out_ready_in  input  1  consumer accepts head.
- imm_out  output  XLEN  immediate.
- imm_type_out  output  3  type code used for this entry.
- tag_out  output  TAG_W  tag of this entry.
- err_out  output  1  auto mode only: unrecognised opcode; imm_out forced to 0.

## Operation
Type codes and forms. S = instr[31] replicated to XLEN.
- 000, I-ALU: S : instr[31:20]
- 001, I-load: S : instr[31:20]
- 010, S-type: S : instr[31:25] : instr[11:7]
- 011, B-type: S : instr[7] : instr[30:25] : instr[11:8] : 0
- 100, U-type: S (XLEN>32 only) : instr[31:12] : 12'h000
- 101, J-type: S : instr[19:12] : instr[20] : instr[30:21] : 0
- 110, CSR zimm: zero-extend instr[19:15]
- 111, I-JALR: S : instr[31:20]

Auto mode (AUTO_TYPE=1), decoded from instr[6:0]:
- 0010011 -> 000; 0011011 -> 000 (XLEN=64 only).
- 0000011 -> 001; 0100011 -> 010; 1100011 -> 011.
- 0110111 / 0010111 -> 100; 1101111 -> 101; 1100111 -> 111.
- 1110011 -> 110 if instr[14]=1, else 000.
- Anything else, including instr[1:0]!=11: err_out=1, imm_out=0, imm_type_out=000.
- err_out is always 0 when AUTO_TYPE=0.

Queue:
- 2 entries; each holds {imm, type, tag, err}; FIFO order; occupancy count 0..2.
- Push when in_valid_in && in_ready_out. Pop when out_valid_out && out_ready_in.
- in_ready_out = (count<2), registered from next-state count.
- out_valid_out = (count!=0). Outputs reflect the head entry.

## Timing
- Reset (rst_n_in=0 at an edge) values: count=0, in_ready_out=1, out_valid_out=0, imm_out=0, imm_type_out=0, tag_out=0, err_out=0.
- Reset mid-operation discards all queued entries; no result is emitted for them.
- Latency: an instruction accepted at edge N is presented at the head after edge N if the queue was empty, with out_valid_out=1 in cycle N+1.
- Simultaneous push and pop with count=1: count stays 1 and the new entry becomes head after the edge. Full throughput holds with out_ready_in held at 1.
- count=2: in_ready_out=0 and in_valid_in is ignored. A pop in that cycle sets count=1, and in_ready_out=1 from the next cycle. No same-cycle refill.
- Pop with count=0 is impossible because out_valid_out=0.
- Head outputs hold stable while out_valid_out=1 and out_ready_in=0.
- No combinational path from out_ready_in to in_ready_out.

## Test plan
- XLEN=32, AUTO_TYPE=0: instr=0xFFF00093 (addi x1,x0,-1), type 000 -> imm_out=0xFFFFFFFF one cycle later, tag echoed.
- B-type 0xFE000EE3 (beq x0,x0,-4), type 011 -> imm_out=0xFFFFFFFC. J-type 0x0000006F -> imm_out=0.
- XLEN=64, AUTO_TYPE=1: instr=0x800000B7 (lui) -> imm_out=0xFFFFFFFF80000000, type 100. csrrwi 0x3400D073 -> imm_out=1, type 110.
- AUTO_TYPE=1, instr=0x0000007F -> err_out=1, imm_out=0. instr[1:0]=00 -> err_out=1.
- Backpressure: stream 5 instructions with out_ready_in=0 -> exactly 2 accepted and in_ready_out=0. Release -> 2 emitted in order, then ready returns and the remaining 3 flow one per cycle.
- Assert rst_n_in low with 2 entries queued -> next cycle out_valid_out=0, in_ready_out=1, all outputs 0. Entries are lost.
